// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with valid/ready handshakes on both sides.
// Define PIPE_STAGE_FWD_EN to build the forwarding tap; otherwise fwd_* are tied to 0.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_wr,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_wr,

    output logic [1:0]        occupancy,

    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DEST_W-1:0] main_dest_q,  main_dest_d;
    logic              main_wr_q,    main_wr_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DEST_W-1:0] skid_dest_q,  skid_dest_d;
    logic              skid_wr_q,    skid_wr_d;

    logic accept;
    logic drain;

    // in_ready depends only on the skid register, so no in_* -> in_ready path exists.
    assign accept = in_valid & ~skid_valid_q;
    assign drain  = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        main_dest_d  = main_dest_q;
        main_wr_d    = main_wr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_dest_d  = skid_dest_q;
        skid_wr_d    = skid_wr_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full implies main full; input is blocked this cycle.
            if (drain) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                main_dest_d  = skid_dest_q;
                main_wr_d    = skid_wr_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || out_ready) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
                main_dest_d  = in_dest;
                main_wr_d    = in_wr;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
                skid_dest_d  = in_dest;
                skid_wr_d    = in_wr;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            main_dest_q  <= '0;
            main_wr_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            skid_dest_q  <= '0;
            skid_wr_q    <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            main_dest_q  <= main_dest_d;
            main_wr_q    <= main_wr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_dest_q  <= skid_dest_d;
            skid_wr_q    <= skid_wr_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_dest  = main_dest_q;
    // A stale write enable must never leak out of an empty stage.
    assign out_wr    = main_valid_q & main_wr_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_FWD_EN
    assign fwd_valid = main_valid_q & main_wr_q & (main_dest_q != '0);
    assign fwd_dest  = main_dest_q;
    assign fwd_data  = main_data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_dest  = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes accepted words, monitor pops on output transfer.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] ctrl;
        logic [4:0]  dest;
        logic        wr;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic [4:0]  in_dest = '0;
    logic        in_wr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] out_ctrl;
    logic [4:0]  out_dest;
    logic        out_wr;
    logic [1:0]  occupancy;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    word_t exp_q[$];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEST_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_dest   (in_dest),
        .in_wr     (in_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_dest  (out_dest),
        .out_wr    (out_wr),
        .occupancy (occupancy),
        .fwd_valid (fwd_valid),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            word_t exp;
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got data 0x%0h expected no word", out_data);
            end else begin
                exp = exp_q.pop_front();
                if ({out_data, out_ctrl, out_dest, out_wr} !== exp) begin
                    errors++;
                    $display("FAIL out_word: got d=0x%0h c=0x%0h dst=%0d wr=%0b expected d=0x%0h c=0x%0h dst=%0d wr=%0b",
                             out_data, out_ctrl, out_dest, out_wr,
                             exp.data, exp.ctrl, exp.dest, exp.wr);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic [4:0] dst, input logic wr);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[15:0] ^ 16'h5A5A;
        in_dest  = dst;
        in_wr    = wr;
    endtask

    // One clock: record an accepted word, then return #1 after the rising edge.
    task automatic step();
        @(negedge clk);
        if (flush) exp_q.delete();
        else if (rst_n && in_valid && in_ready)
            exp_q.push_back({in_data, in_ctrl, in_dest, in_wr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_wr", out_wr, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming 1..8, one-cycle latency, back-to-back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(i, 5'(i), 1'b1);
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_wr", out_wr, 0);
        chk("stream_end_occ", occupancy, 0);

        // Stall with skid fill, then release while input is blocked
        out_ready = 1'b0;
        drive(32'hA, 5'd1, 1'b1);
        step();
        drive(32'hB, 5'd2, 1'b0);
        step();
        in_valid = 1'b0;
        chk("stall_occ", occupancy, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_data", out_data, 32'hA);
        step();
        step();
        chk("stall_hold_data", out_data, 32'hA);
        chk("stall_hold_occ", occupancy, 2);
        out_ready = 1'b1;
        drive(32'hD, 5'd3, 1'b1);
        step();
        chk("release_data_b", out_data, 32'hB);
        chk("release_in_ready", in_ready, 1);
        chk("release_occ", occupancy, 1);
        step();
        chk("release_data_d", out_data, 32'hD);
        in_valid = 1'b0;
        step();
        chk("release_end_occ", occupancy, 0);

        // Flush with both entries full and input presented
        out_ready = 1'b0;
        drive(32'h21, 5'd4, 1'b1);
        step();
        drive(32'h22, 5'd4, 1'b1);
        step();
        chk("flush2_pre_occ", occupancy, 2);
        drive(32'hC, 5'd6, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush2_occ", occupancy, 0);
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_in_ready", in_ready, 1);

        // Flush while input would otherwise be accepted
        drive(32'h31, 5'd7, 1'b1);
        step();
        drive(32'hC, 5'd6, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1_occ", occupancy, 0);
        chk("flush1_out_valid", out_valid, 0);
        out_ready = 1'b1;
        drive(32'h41, 5'd8, 1'b0);
        step();
        chk("post_flush_data", out_data, 32'h41);
        in_valid = 1'b0;
        step();

        // Forwarding tap
        out_ready = 1'b0;
        drive(32'h1234, 5'd5, 1'b1);
        step();
        in_valid = 1'b0;
        chk("fwd_out_wr", out_wr, 1);
`ifdef PIPE_STAGE_FWD_EN
        chk("fwd_valid_d5", fwd_valid, 1);
        chk("fwd_dest_d5", fwd_dest, 5);
        chk("fwd_data_d5", fwd_data, 32'h1234);
`else
        chk("fwd_valid_d5", fwd_valid, 0);
        chk("fwd_dest_d5", fwd_dest, 0);
        chk("fwd_data_d5", fwd_data, 0);
`endif
        out_ready = 1'b1;
        step();
        chk("fwd_valid_empty", fwd_valid, 0);
        out_ready = 1'b0;
        drive(32'h5678, 5'd0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("fwd_valid_d0", fwd_valid, 0);
`ifdef PIPE_STAGE_FWD_EN
        chk("fwd_data_d0", fwd_data, 32'h5678);
`else
        chk("fwd_data_d0", fwd_data, 0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(32'h9ABC, 5'd5, 1'b0);
        step();
        in_valid = 1'b0;
        chk("fwd_valid_wr0", fwd_valid, 0);
        chk("out_wr_wr0", out_wr, 0);
        out_ready = 1'b1;
        step();

        // Asynchronous reset mid-stream with both entries full
        out_ready = 1'b0;
        drive(32'h51, 5'd9, 1'b1);
        step();
        drive(32'h52, 5'd9, 1'b1);
        step();
        in_valid = 1'b0;
        chk("arst_pre_occ", occupancy, 2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_occ", occupancy, 0);
        chk("arst_out_wr", out_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(32'h61, 5'd10, 1'b1);
        step();
        chk("arst_resume_data", out_data, 32'h61);
        in_valid = 1'b0;

        // Drain with a bounded wait
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) step();
        step();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_pop_count", pops, 16);
        chk("final_occ", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
